// File: rtl/tx_framing_realign_buffer.sv
// TX framing realignment buffer: prepends a framing token to each TLP and shifts
// the payload across the beat, carrying displaced tail bytes into the next beat.
module tx_framing_realign_buffer #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int LANES        = 16,
    parameter int TOKEN_BYTES  = 4,
    parameter int CNT_WIDTH    = $clog2(LANES + 1)
) (
    input  logic                                  CLK,
    input  logic                                  RST_L,
    input  logic                                  i_Valid,
    output logic                                  o_Rdy,
    input  logic                                  i_Sop,
    input  logic                                  i_Eop,
    input  logic [CNT_WIDTH-1:0]                  i_Byte_Cnt,
    input  logic [0:LANES*SYMBOL_WIDTH-1]         i_Data,
    input  logic [0:TOKEN_BYTES*SYMBOL_WIDTH-1]   i_Token,
    input  logic                                  i_Rdy,
    output logic                                  o_Valid,
    output logic                                  o_Sop,
    output logic                                  o_Eop,
    output logic [CNT_WIDTH-1:0]                  o_Byte_Cnt,
    output logic [0:LANES*SYMBOL_WIDTH-1]         o_Data,
    output logic                                  o_Err
);

    localparam int SW = SYMBOL_WIDTH;
    localparam int T  = TOKEN_BYTES;
    localparam int R  = LANES - TOKEN_BYTES;
    localparam int BW = LANES * SYMBOL_WIDTH;
    localparam int TW = TOKEN_BYTES * SYMBOL_WIDTH;
    localparam int NW = CNT_WIDTH + 1;
    localparam logic [NW-1:0]        LANES_N = NW'(LANES);
    localparam logic [NW-1:0]        T_N     = NW'(TOKEN_BYTES);
    localparam logic [CNT_WIDTH-1:0] LANES_C = CNT_WIDTH'(LANES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PKT   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [0:TW-1]          resid_r, resid_nxt_s;
    logic [CNT_WIDTH-1:0]   flush_cnt_r, flush_cnt_nxt_s;
    logic                   valid_r, valid_nxt_s;
    logic                   sop_r, sop_nxt_s;
    logic                   eop_r, eop_nxt_s;
    logic                   err_r, err_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_nxt_s;
    logic [0:BW-1]          data_r, data_nxt_s;

    logic                   advance_s;
    logic                   accept_s;
    logic [NW-1:0]          k_s;
    logic [NW-1:0]          n_s;
    logic [CNT_WIDTH-1:0]   ovf_s;
    logic [0:TW-1]          head_s;
    logic [0:BW-1]          beat_s;
    logic [0:TW-1]          tail_s;
    logic [0:BW-1]          beat_trim_s;
    logic [0:TW-1]          tail_trim_s;

    assign advance_s = i_Rdy || !valid_r;
    assign o_Rdy     = advance_s && (state_r != ST_FLUSH);
    assign accept_s  = i_Valid && o_Rdy;

    assign head_s = i_Sop ? i_Token : resid_r;
    assign beat_s = {head_s, i_Data[0:R*SW-1]};
    assign tail_s = i_Data[R*SW:BW-1];
    assign n_s    = k_s + T_N;
    assign ovf_s  = CNT_WIDTH'(n_s - LANES_N);

    // Out-of-range byte counts are treated as a full beat
    always_comb begin
        if ((i_Byte_Cnt == {CNT_WIDTH{1'b0}}) || ({1'b0, i_Byte_Cnt} > LANES_N)) begin
            k_s = LANES_N;
        end else begin
            k_s = {1'b0, i_Byte_Cnt};
        end
    end

    // Zero bytes past the end of the packet in the final beat and in the carried residual
    always_comb begin
        beat_trim_s = {BW{1'b0}};
        tail_trim_s = {TW{1'b0}};
        for (int b = 0; b < LANES; b++) begin
            beat_trim_s[b*SW +: SW] = (NW'(b) < n_s) ? beat_s[b*SW +: SW] : {SW{1'b0}};
        end
        for (int j = 0; j < T; j++) begin
            tail_trim_s[j*SW +: SW] = (CNT_WIDTH'(j) < ovf_s) ? tail_s[j*SW +: SW] : {SW{1'b0}};
        end
    end

    // Next-state and next-output decode; everything holds while downstream stalls
    always_comb begin
        state_nxt_s     = state_r;
        resid_nxt_s     = resid_r;
        flush_cnt_nxt_s = flush_cnt_r;
        valid_nxt_s     = valid_r;
        sop_nxt_s       = sop_r;
        eop_nxt_s       = eop_r;
        cnt_nxt_s       = cnt_r;
        data_nxt_s      = data_r;
        err_nxt_s       = 1'b0;
        if (advance_s) begin
            case (state_r)
                ST_FLUSH: begin
                    valid_nxt_s = 1'b1;
                    sop_nxt_s   = 1'b0;
                    eop_nxt_s   = 1'b1;
                    cnt_nxt_s   = flush_cnt_r;
                    data_nxt_s  = {resid_r, {(R*SW){1'b0}}};
                    resid_nxt_s = {TW{1'b0}};
                    state_nxt_s = ST_IDLE;
                end
                ST_IDLE, ST_PKT: begin
                    if (!accept_s) begin
                        valid_nxt_s = 1'b0;
                        sop_nxt_s   = 1'b0;
                        eop_nxt_s   = 1'b0;
                    end else if (!i_Sop && (state_r == ST_IDLE)) begin
                        valid_nxt_s = 1'b0;
                        sop_nxt_s   = 1'b0;
                        eop_nxt_s   = 1'b0;
                        err_nxt_s   = 1'b1;
                    end else begin
                        // A Sop arriving mid-packet abandons the old residual via head_s
                        err_nxt_s   = i_Sop && (state_r == ST_PKT);
                        valid_nxt_s = 1'b1;
                        sop_nxt_s   = i_Sop;
                        resid_nxt_s = tail_s;
                        if (!i_Eop) begin
                            eop_nxt_s   = 1'b0;
                            cnt_nxt_s   = LANES_C;
                            data_nxt_s  = beat_s;
                            state_nxt_s = ST_PKT;
                        end else if (n_s <= LANES_N) begin
                            eop_nxt_s   = 1'b1;
                            cnt_nxt_s   = n_s[CNT_WIDTH-1:0];
                            data_nxt_s  = beat_trim_s;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            eop_nxt_s       = 1'b0;
                            cnt_nxt_s       = LANES_C;
                            data_nxt_s      = beat_s;
                            resid_nxt_s     = tail_trim_s;
                            flush_cnt_nxt_s = ovf_s;
                            state_nxt_s     = ST_FLUSH;
                        end
                    end
                end
                default: begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, residual and registered output beat
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_r     <= ST_IDLE;
            resid_r     <= {TW{1'b0}};
            flush_cnt_r <= {CNT_WIDTH{1'b0}};
            valid_r     <= 1'b0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= {CNT_WIDTH{1'b0}};
            data_r      <= {BW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            resid_r     <= resid_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
            valid_r     <= valid_nxt_s;
            sop_r       <= sop_nxt_s;
            eop_r       <= eop_nxt_s;
            err_r       <= err_nxt_s;
            cnt_r       <= cnt_nxt_s;
            data_r      <= data_nxt_s;
        end
    end

    assign o_Valid    = valid_r;
    assign o_Sop      = sop_r;
    assign o_Eop      = eop_r;
    assign o_Err      = err_r;
    assign o_Byte_Cnt = cnt_r;
    assign o_Data     = data_r;

endmodule

// File: tb/tb_tx_framing_realign_buffer.sv
// Bench for tx_framing_realign_buffer at LANES=4, TOKEN_BYTES=2: directed scenarios
// plus random traffic checked against a byte-stream packet model.
module tb_tx_framing_realign_buffer;

    localparam int SW    = 8;
    localparam int LANES = 4;
    localparam int TB    = 2;
    localparam int CW    = $clog2(LANES + 1);
    localparam int BW    = LANES * SW;

    logic           CLK;
    logic           RST_L;
    logic           i_Valid, i_Sop, i_Eop, i_Rdy;
    logic [CW-1:0]  i_Byte_Cnt;
    logic [0:BW-1]  i_Data;
    logic [0:TB*SW-1] i_Token;
    logic           o_Rdy, o_Valid, o_Sop, o_Eop, o_Err;
    logic [CW-1:0]  o_Byte_Cnt;
    logic [0:BW-1]  o_Data;

    int   check_cnt = 0;
    int   fail_cnt  = 0;
    logic rdy_seen;

    // Byte-stream reference model state
    logic [7:0]     pend[$];
    logic           mv, msop, meop, merr, in_pkt, flush_m;
    logic [CW-1:0]  mcnt;
    logic [0:BW-1]  mdata;

    tx_framing_realign_buffer #(
        .SYMBOL_WIDTH(SW), .LANES(LANES), .TOKEN_BYTES(TB), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RST_L(RST_L), .i_Valid(i_Valid), .o_Rdy(o_Rdy),
        .i_Sop(i_Sop), .i_Eop(i_Eop), .i_Byte_Cnt(i_Byte_Cnt), .i_Data(i_Data),
        .i_Token(i_Token), .i_Rdy(i_Rdy), .o_Valid(o_Valid), .o_Sop(o_Sop),
        .o_Eop(o_Eop), .o_Byte_Cnt(o_Byte_Cnt), .o_Data(o_Data), .o_Err(o_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [CW-1:0] k, input logic [0:BW-1] d, input logic r);
        i_Valid = v; i_Sop = s; i_Eop = e; i_Byte_Cnt = k; i_Data = d; i_Rdy = r;
        #1;
        rdy_seen = o_Rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    endtask

    task automatic model_emit(input int n, input logic s, input logic e);
        mdata = '0;
        for (int b = 0; b < LANES; b++) begin
            if (b < n) mdata[b*SW +: SW] = pend.pop_front();
        end
        mv = 1'b1; msop = s; meop = e; mcnt = CW'(n);
    endtask

    task automatic test_reset();
        RST_L = 1'b0; i_Token = 16'hFB00;
        i_Valid = 1'b0; i_Sop = 1'b0; i_Eop = 1'b0; i_Byte_Cnt = 3'd0; i_Data = 32'h0; i_Rdy = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, o_Rdy} !== {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1}) begin
            fail_cnt++;
            $display("FAIL reset_values: got v%b s%b e%b err%b cnt%0d d%h rdy%b, expected all 0 with rdy=1",
                     o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, o_Rdy);
        end
        @(negedge CLK);
        RST_L = 1'b1;
        idle();
    endtask

    task automatic test_single_beat_overflow();
        drive(1'b1, 1'b1, 1'b1, 3'd3, 32'hA1A2A3A4, 1'b1);
        check_cnt++;
        if ({rdy_seen, o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, o_Rdy} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'hFB00A1A2, 1'b0}) begin
            fail_cnt++;
            $display("FAIL single_first: got v%b s%b e%b cnt%0d d%h rdy%b, expected v1 s1 e0 cnt4 dFB00A1A2 rdy0",
                     o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data, o_Rdy);
        end
        idle();
        check_cnt++;
        if ({rdy_seen, o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'hA3000000}) begin
            fail_cnt++;
            $display("FAIL single_flush: got v%b s%b e%b cnt%0d d%h rdy%b, expected v1 s0 e1 cnt1 dA3000000 rdy0",
                     o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data, rdy_seen);
        end
        idle();
        check_cnt++;
        if (o_Valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_drain: got o_Valid=%b expected 0", o_Valid);
        end
    endtask

    task automatic test_exact_fit();
        drive(1'b1, 1'b1, 1'b1, 3'd2, 32'hB1B2C3C4, 1'b1);
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, o_Rdy} !== {1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 32'hFB00B1B2, 1'b1}) begin
            fail_cnt++;
            $display("FAIL exact_fit: got v%b s%b e%b cnt%0d d%h rdy%b, expected v1 s1 e1 cnt4 dFB00B1B2 rdy1",
                     o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data, o_Rdy);
        end
        idle();
    endtask

    task automatic test_three_beat();
        logic [0:BW-1] exp_d[3];
        logic [2:0]    exp_se[3];
        exp_d[0] = 32'hFB000102; exp_d[1] = 32'h03040506; exp_d[2] = 32'h0708090A;
        exp_se[0] = 3'b100; exp_se[1] = 3'b000; exp_se[2] = 3'b010;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h01020304, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_cnt++;
            if ({rdy_seen, o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data} !== {1'b1, 1'b1, exp_se[i], 3'd4, exp_d[i]}) begin
                fail_cnt++;
                $display("FAIL three_beat[%0d]: got rdy%b v%b s%b e%b cnt%0d d%h, expected rdy1 v1 se%b cnt4 d%h",
                         i, rdy_seen, o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data, exp_se[i][2:1], exp_d[i]);
            end
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h05060708, 1'b1);
            else if (i == 1) drive(1'b1, 1'b0, 1'b1, 3'd2, 32'h090A0B0C, 1'b1);
        end
        check_cnt++;
        if (o_Rdy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL three_beat_bubble: got o_Rdy=%b expected 1", o_Rdy);
        end
        idle();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h11121314, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h15161718, 1'b0);
            check_cnt++;
            if ({rdy_seen, o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 32'hFB001112}) begin
                fail_cnt++;
                $display("FAIL bp_hold[%0d]: got rdy%b v%b s%b e%b cnt%0d d%h, expected rdy0 v1 s1 e0 cnt4 dFB001112",
                         i, rdy_seen, o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h15161718, 1'b1);
        check_cnt++;
        if ({rdy_seen, o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h13141516}) begin
            fail_cnt++;
            $display("FAIL bp_release: got rdy%b v%b s%b e%b cnt%0d d%h, expected rdy1 v1 s0 e0 cnt4 d13141516",
                     rdy_seen, o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd4, 32'h191A1B1C, 1'b1);
        check_cnt++;
        if ({o_Valid, o_Eop, o_Byte_Cnt, o_Data, o_Rdy} !== {1'b1, 1'b0, 3'd4, 32'h1718191A, 1'b0}) begin
            fail_cnt++;
            $display("FAIL bp_eop: got v%b e%b cnt%0d d%h rdy%b, expected v1 e0 cnt4 d1718191A rdy0",
                     o_Valid, o_Eop, o_Byte_Cnt, o_Data, o_Rdy);
        end
        idle();
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data} !== {1'b1, 1'b0, 1'b1, 3'd2, 32'h1B1C0000}) begin
            fail_cnt++;
            $display("FAIL bp_flush: got v%b s%b e%b cnt%0d d%h, expected v1 s0 e1 cnt2 d1B1C0000",
                     o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data);
        end
        idle();
    endtask

    task automatic test_protocol_errors();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 1'b1);
        check_cnt++;
        if ({o_Valid, o_Err} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL err_idle: got v%b err%b expected v0 err1", o_Valid, o_Err);
        end
        idle();
        check_cnt++;
        if ({o_Valid, o_Err} !== 2'b00) begin
            fail_cnt++;
            $display("FAIL err_pulse: got v%b err%b expected v0 err0", o_Valid, o_Err);
        end
        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h21222324, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h31323334, 1'b1);
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Err, o_Data} !== {1'b1, 1'b1, 1'b0, 1'b1, 32'hFB003132}) begin
            fail_cnt++;
            $display("FAIL err_sop_pkt: got v%b s%b e%b err%b d%h, expected v1 s1 e0 err1 dFB003132",
                     o_Valid, o_Sop, o_Eop, o_Err, o_Data);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd1, 32'h35363738, 1'b1);
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'h33343500}) begin
            fail_cnt++;
            $display("FAIL err_new_pkt_tail: got v%b s%b e%b err%b cnt%0d d%h, expected v1 s0 e1 err0 cnt3 d33343500",
                     o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data);
        end
        idle();
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b1, 1'b1, 1'b1, 3'd4, 32'h41424344, 1'b1);
        #2;
        RST_L = 1'b0;
        #1;
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, o_Rdy} !== {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1}) begin
            fail_cnt++;
            $display("FAIL rst_flush: got v%b s%b e%b err%b cnt%0d d%h rdy%b, expected all 0 with rdy=1",
                     o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, o_Rdy);
        end
        @(negedge CLK);
        RST_L = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'd2, 32'h51525354, 1'b1);
        check_cnt++;
        if ({o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data} !== {1'b1, 1'b1, 1'b1, 3'd4, 32'hFB005152}) begin
            fail_cnt++;
            $display("FAIL rst_next_sop: got v%b s%b e%b cnt%0d d%h, expected v1 s1 e1 cnt4 dFB005152",
                     o_Valid, o_Sop, o_Eop, o_Byte_Cnt, o_Data);
        end
        idle();
    endtask

    task automatic test_random();
        logic v, s, e, r, adv, rdy_m;
        logic [CW-1:0] k;
        logic [0:BW-1] d;
        int nb;
        @(negedge CLK); RST_L = 1'b0;
        @(negedge CLK); RST_L = 1'b1;
        pend.delete();
        mv = 1'b0; msop = 1'b0; meop = 1'b0; merr = 1'b0; in_pkt = 1'b0; flush_m = 1'b0;
        mcnt = '0; mdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v = ($urandom_range(0, 99) < 70);
            s = ($urandom_range(0, 99) < 30);
            e = ($urandom_range(0, 99) < 40);
            k = e ? CW'($urandom_range(1, LANES)) : CW'($urandom_range(0, 7));
            d = $urandom();
            r = ($urandom_range(0, 99) < 75);
            i_Token = 16'($urandom_range(0, 65535));
            adv   = r || !mv;
            rdy_m = adv && !flush_m;
            if (adv) begin
                merr = 1'b0;
                if (flush_m) begin
                    model_emit(pend.size(), 1'b0, 1'b1);
                    flush_m = 1'b0;
                    in_pkt  = 1'b0;
                end else if (v && (s || in_pkt)) begin
                    if (s) begin
                        merr = in_pkt;
                        pend.delete();
                        for (int j = 0; j < TB; j++) pend.push_back(i_Token[j*SW +: SW]);
                        in_pkt = 1'b1;
                    end
                    nb = e ? int'(k) : LANES;
                    for (int j = 0; j < nb; j++) pend.push_back(d[j*SW +: SW]);
                    if (!e) begin
                        model_emit(LANES, s, 1'b0);
                    end else if (pend.size() <= LANES) begin
                        model_emit(pend.size(), s, 1'b1);
                        in_pkt = 1'b0;
                    end else begin
                        model_emit(LANES, s, 1'b0);
                        flush_m = 1'b1;
                    end
                end else begin
                    mv   = 1'b0;
                    merr = v;
                end
            end else begin
                merr = 1'b0;
            end
            drive(v, s, e, k, d, r);
            check_cnt++;
            if (rdy_seen !== rdy_m) begin
                fail_cnt++;
                $display("FAIL rand_rdy[%0d]: got o_Rdy=%b expected %b", cyc, rdy_seen, rdy_m);
            end
            check_cnt++;
            if (mv && ({o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data} !== {1'b1, msop, meop, merr, mcnt, mdata})) begin
                fail_cnt++;
                $display("FAIL rand_beat[%0d]: got v%b s%b e%b err%b cnt%0d d%h, expected v1 s%b e%b err%b cnt%0d d%h",
                         cyc, o_Valid, o_Sop, o_Eop, o_Err, o_Byte_Cnt, o_Data, msop, meop, merr, mcnt, mdata);
            end else if (!mv && ({o_Valid, o_Err} !== {1'b0, merr})) begin
                fail_cnt++;
                $display("FAIL rand_idle[%0d]: got v%b err%b expected v0 err%b", cyc, o_Valid, o_Err, merr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat_overflow();
        test_exact_fit();
        test_three_beat();
        test_backpressure();
        test_protocol_errors();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
